// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types, constants and phase-length helpers for the clock divider.
//   state_e   - FSM state encoding (IDLE, HIGH, LOW)
//   DIV_MIN   - smallest usable divide ratio
//   eff_div   - clamps a requested ratio to at least DIV_MIN
//   high_len  - high-phase length, ceil(ratio/2)
//   low_len   - low-phase length, floor(ratio/2)
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    function automatic int unsigned eff_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Odd ratios put the extra cycle in the high phase.
    function automatic int unsigned high_len(input int unsigned d);
        return (d + 1) / 2;
    endfunction

    function automatic int unsigned low_len(input int unsigned d);
        return d / 2;
    endfunction

endpackage

// File: rtl/clkdiv_en_sync.sv
// clkdiv_en_sync: two-flop synchronizer bringing the run request into the CLK domain.
//   CLK  - destination clock
//   RN   - synchronous active-low reset, clears both flops
//   d_i  - asynchronous input
//   q_o  - synchronized output, two CLK cycles behind d_i
module clkdiv_en_sync (
    input  logic CLK,
    input  logic RN,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    assign sync_d = RN ? {sync_q[0], d_i} : 2'b00;

    always_ff @(posedge CLK) begin
        sync_q <= sync_d;
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/clkdiv_gate_ctrl.sv
// clkdiv_gate_ctrl: glitch-free programmable clock divider with run/stop gating.
//   CLK  - source clock, rising edge
//   RN   - synchronous active-low reset
//   EN   - level-sensitive run request
//   DIV  - divide ratio, 0 and 1 behave as 2
//   CLKO - registered divided clock for the downstream inverter stage
//   RUN  - high while CLKO is toggling
//   TICK - one-CLK pulse with each CLKO rising edge
//   VDD  - power, no logic function
//   VSS  - ground, no logic function
// Define CLKDIV_EN_SYNC_EN to pass EN through a two-flop synchronizer
// (adds two CLK cycles of start latency).
module clkdiv_gate_ctrl
    import clkdiv_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    output logic             CLKO,
    output logic             RUN,
    output logic             TICK,
    inout  wire              VDD,
    inout  wire              VSS
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clko_q, clko_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] div_eff, h_len, l_len;
    logic             en_i;
    wire              unused_pwr = VDD ^ VSS;

`ifdef CLKDIV_EN_SYNC_EN
    clkdiv_en_sync u_en_sync (
        .CLK (CLK),
        .RN  (RN),
        .d_i (EN),
        .q_o (en_i)
    );
`else
    assign en_i = EN;
`endif

    assign div_eff = DIV_W'(eff_div(32'(DIV)));
    assign h_len   = DIV_W'(high_len(32'(div_q)));
    assign l_len   = DIV_W'(low_len(32'(div_q)));

    // The ratio is only (re)loaded when a new period starts, so a mid-period
    // DIV change can never shorten or stretch the pulse currently on CLKO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        clko_d  = clko_q;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = HIGH;
                    cnt_d   = DIV_W'(1);
                    div_d   = div_eff;
                    clko_d  = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == h_len) begin
                    state_d = LOW;
                    cnt_d   = DIV_W'(1);
                    clko_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            LOW: begin
                // Stop is only honoured here, after a complete low phase.
                if (cnt_q == l_len) begin
                    state_d = en_i ? HIGH : IDLE;
                    cnt_d   = en_i ? DIV_W'(1) : '0;
                    div_d   = en_i ? div_eff : div_q;
                    clko_d  = en_i;
                    tick_d  = en_i;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clko_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(DIV_RST);
            clko_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clko_q  <= clko_d;
            tick_q  <= tick_d;
        end
    end

    assign CLKO = clko_q;
    assign TICK = tick_q;
    assign RUN  = (state_q != IDLE);

endmodule
